// File: rtl/ni_param.sv
// ni_param: GPU network interface between one GPU port and its leaf router.
//
// GPU flits {dest_id, payload} are checked and re-headed to
// {dest_id + ADDR_OFFSET, payload}, then queued in the g2r FIFO toward the
// router. Router flits carrying this node's header are restored to
// {header - ADDR_OFFSET, payload} and queued in the r2g FIFO toward the GPU.
// With LOOPBACK_EN set, g2r heads addressed to this node move straight into
// r2g instead of going out to the router.
//
// Ports:
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   gpu_data_in/valid_in/ready_out   GPU -> NI flit handshake
//   gpu_data_out/valid_out/ready_in  NI -> GPU flit handshake (FWFT from r2g)
//   router_data_out/valid_out/ready_in  NI -> router flit handshake (FWFT from g2r)
//   router_data_in/valid_in/ready_out   router -> NI flit handshake
//   g2r_level, r2g_level             FIFO occupancies (0..DEPTH)
//   bad_dest_cnt                     saturating count of GPU flits with invalid dest
//   misroute_cnt                     saturating count of router flits with foreign header

module ni_param_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;

  // Storage is not reset: a flush only needs the pointers and count cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == LVL_W'(DEPTH));
  assign level = count;
endmodule

module ni_param #(
  parameter int unsigned GPU_ID      = 3,
  parameter int unsigned NUM_GPUS    = 32,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ID_W        = 6,
  parameter int unsigned ADDR_OFFSET = 3,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned LOOPBACK_EN = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        gpu_data_in,
  input  logic                     gpu_valid_in,
  output logic                     gpu_ready_out,
  output logic [DATA_W-1:0]        gpu_data_out,
  output logic                     gpu_valid_out,
  input  logic                     gpu_ready_in,
  output logic [DATA_W-1:0]        router_data_out,
  output logic                     router_valid_out,
  input  logic                     router_ready_in,
  input  logic [DATA_W-1:0]        router_data_in,
  input  logic                     router_valid_in,
  output logic                     router_ready_out,
  output logic [$clog2(DEPTH):0]   g2r_level,
  output logic [$clog2(DEPTH):0]   r2g_level,
  output logic [CNT_W-1:0]         bad_dest_cnt,
  output logic [CNT_W-1:0]         misroute_cnt
);
  localparam int unsigned PAY_W = DATA_W - ID_W;
  localparam logic [ID_W-1:0] OFFS    = ID_W'(ADDR_OFFSET);
  localparam logic [ID_W-1:0] MY_ADDR = ID_W'(GPU_ID + ADDR_OFFSET);
  localparam bit LOOP = (LOOPBACK_EN != 0);

  // GPU ingress
  logic [ID_W-1:0]   gpu_dest;
  logic              gpu_dest_bad;
  logic              gpu_fire;
  logic              g2r_push;
  logic [DATA_W-1:0] g2r_push_data;

  // g2r FIFO
  logic [DATA_W-1:0] g2r_head;
  logic              g2r_empty;
  logic              g2r_full;
  logic              g2r_pop;
  logic [ID_W-1:0]   g2r_head_hdr;
  logic              head_is_local;
  logic              loop_move;

  // Router ingress
  logic [ID_W-1:0]   rtr_hdr;
  logic              rtr_fire;
  logic              rtr_accept;

  // r2g FIFO
  logic              r2g_push;
  logic [DATA_W-1:0] r2g_push_data;
  logic [DATA_W-1:0] r2g_head;
  logic              r2g_empty;
  logic              r2g_full;
  logic              r2g_pop;

  assign gpu_ready_out    = !g2r_full;
  assign router_ready_out = !r2g_full;

  assign gpu_dest      = gpu_data_in[DATA_W-1 -: ID_W];
  assign gpu_dest_bad  = (gpu_dest == '0) || (32'(gpu_dest) > NUM_GPUS);
  assign gpu_fire      = gpu_valid_in && gpu_ready_out;
  assign g2r_push      = gpu_fire && !gpu_dest_bad;
  assign g2r_push_data = {gpu_dest + OFFS, gpu_data_in[PAY_W-1:0]};

  assign g2r_head_hdr  = g2r_head[DATA_W-1 -: ID_W];
  assign head_is_local = LOOP && (g2r_head_hdr == MY_ADDR);

  assign router_valid_out = !g2r_empty && !head_is_local;
  assign router_data_out  = router_valid_out ? g2r_head : '0;

  // A local head waits while the router is offering a flit: the router owns
  // the single r2g write port that cycle, and g2r stays strictly in order.
  assign loop_move = !g2r_empty && head_is_local && !r2g_full && !router_valid_in;
  assign g2r_pop   = (router_valid_out && router_ready_in) || loop_move;

  assign rtr_hdr    = router_data_in[DATA_W-1 -: ID_W];
  assign rtr_fire   = router_valid_in && router_ready_out;
  assign rtr_accept = rtr_fire && (rtr_hdr == MY_ADDR);

  // loop_move and rtr_fire are mutually exclusive (loop_move needs !router_valid_in).
  always_comb begin
    r2g_push      = 1'b0;
    r2g_push_data = '0;
    if (rtr_accept) begin
      r2g_push      = 1'b1;
      r2g_push_data = {rtr_hdr - OFFS, router_data_in[PAY_W-1:0]};
    end else if (loop_move) begin
      r2g_push      = 1'b1;
      r2g_push_data = {g2r_head_hdr - OFFS, g2r_head[PAY_W-1:0]};
    end
  end

  assign gpu_valid_out = !r2g_empty;
  assign gpu_data_out  = gpu_valid_out ? r2g_head : '0;
  assign r2g_pop       = gpu_valid_out && gpu_ready_in;

  ni_param_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_g2r (
    .clk       (clk),
    .reset     (reset),
    .push      (g2r_push),
    .push_data (g2r_push_data),
    .pop       (g2r_pop),
    .head      (g2r_head),
    .empty     (g2r_empty),
    .full      (g2r_full),
    .level     (g2r_level)
  );

  ni_param_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_r2g (
    .clk       (clk),
    .reset     (reset),
    .push      (r2g_push),
    .push_data (r2g_push_data),
    .pop       (r2g_pop),
    .head      (r2g_head),
    .empty     (r2g_empty),
    .full      (r2g_full),
    .level     (r2g_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bad_dest_cnt <= '0;
      misroute_cnt <= '0;
    end else begin
      if (gpu_fire && gpu_dest_bad && (bad_dest_cnt != '1)) begin
        bad_dest_cnt <= bad_dest_cnt + 1'b1;
      end
      if (rtr_fire && !rtr_accept && (misroute_cnt != '1)) begin
        misroute_cnt <= misroute_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ni_param.sv
module tb_ni_param;
  logic        clk;
  logic        reset;
  logic [15:0] gpu_data_in;
  logic        gpu_valid_in;
  logic        gpu_ready_in;
  logic [15:0] router_data_in;
  logic        router_valid_in;
  logic        router_ready_in;

  logic        gpu_ready_out, gpu_valid_out, router_valid_out, router_ready_out;
  logic [15:0] gpu_data_out, router_data_out;
  logic [3:0]  g2r_level, r2g_level;
  logic [7:0]  bad_dest_cnt, misroute_cnt;

  logic        gpu_ready_out5, gpu_valid_out5, router_valid_out5, router_ready_out5;
  logic [15:0] gpu_data_out5, router_data_out5;
  logic [3:0]  g2r_level5, r2g_level5;
  logic [7:0]  bad_dest_cnt5, misroute_cnt5;

  int tests;
  int failed;

  ni_param #(.GPU_ID(3), .LOOPBACK_EN(1)) u_dut (
    .clk(clk), .reset(reset),
    .gpu_data_in(gpu_data_in), .gpu_valid_in(gpu_valid_in), .gpu_ready_out(gpu_ready_out),
    .gpu_data_out(gpu_data_out), .gpu_valid_out(gpu_valid_out), .gpu_ready_in(gpu_ready_in),
    .router_data_out(router_data_out), .router_valid_out(router_valid_out),
    .router_ready_in(router_ready_in), .router_data_in(router_data_in),
    .router_valid_in(router_valid_in), .router_ready_out(router_ready_out),
    .g2r_level(g2r_level), .r2g_level(r2g_level),
    .bad_dest_cnt(bad_dest_cnt), .misroute_cnt(misroute_cnt)
  );

  ni_param #(.GPU_ID(5), .LOOPBACK_EN(1)) u_dut5 (
    .clk(clk), .reset(reset),
    .gpu_data_in(gpu_data_in), .gpu_valid_in(gpu_valid_in), .gpu_ready_out(gpu_ready_out5),
    .gpu_data_out(gpu_data_out5), .gpu_valid_out(gpu_valid_out5), .gpu_ready_in(gpu_ready_in),
    .router_data_out(router_data_out5), .router_valid_out(router_valid_out5),
    .router_ready_in(router_ready_in), .router_data_in(router_data_in),
    .router_valid_in(router_valid_in), .router_ready_out(router_ready_out5),
    .g2r_level(g2r_level5), .r2g_level(r2g_level5),
    .bad_dest_cnt(bad_dest_cnt5), .misroute_cnt(misroute_cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    gpu_data_in     = '0;
    gpu_valid_in    = 1'b0;
    gpu_ready_in    = 1'b0;
    router_data_in  = '0;
    router_valid_in = 1'b0;
    router_ready_in = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    tick();
    tests++; if (gpu_valid_out !== 1'b0 || router_valid_out !== 1'b0) begin
      failed++; $display("FAIL reset_valids: got gpu=%b rtr=%b want 0 0", gpu_valid_out, router_valid_out); end
    tests++; if (gpu_data_out !== 16'h0 || router_data_out !== 16'h0) begin
      failed++; $display("FAIL reset_data: got gpu=%h rtr=%h want 0 0", gpu_data_out, router_data_out); end
    tests++; if (g2r_level !== 4'd0 || r2g_level !== 4'd0) begin
      failed++; $display("FAIL reset_levels: got %0d %0d want 0 0", g2r_level, r2g_level); end
    tests++; if (bad_dest_cnt !== 8'd0 || misroute_cnt !== 8'd0) begin
      failed++; $display("FAIL reset_counters: got %0d %0d want 0 0", bad_dest_cnt, misroute_cnt); end
    tests++; if (gpu_ready_out !== 1'b1 || router_ready_out !== 1'b1) begin
      failed++; $display("FAIL reset_readies: got %b %b want 1 1", gpu_ready_out, router_ready_out); end
  endtask

  // GPU_ID=5 instance: dest 3 is remote, so the flit goes to the router with header 6.
  task automatic test_single;
    do_reset();
    gpu_data_in  = 16'h0C05;
    gpu_valid_in = 1'b1;
    tick();
    gpu_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (router_valid_out5 !== 1'b1 || router_data_out5 !== 16'h1805) begin
        failed++; $display("FAIL single_hold[%0d]: got v=%b d=%h want v=1 d=1805", i, router_valid_out5, router_data_out5); end
      tick();
    end
    router_ready_in = 1'b1;
    tick();
    router_ready_in = 1'b0;
    tests++; if (router_valid_out5 !== 1'b0 || g2r_level5 !== 4'd0) begin
      failed++; $display("FAIL single_drain: got v=%b lvl=%0d want v=0 lvl=0", router_valid_out5, g2r_level5); end
  endtask

  // dest 5 -> header 8: flit k goes in as 0x1400+k and out as 0x2000+k.
  task automatic test_fill_drain;
    logic [15:0] exp;
    do_reset();
    gpu_valid_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      gpu_data_in = 16'h1400 + 16'(k);
      tick();
    end
    tests++; if (g2r_level !== 4'd8 || gpu_ready_out !== 1'b0) begin
      failed++; $display("FAIL fill_full: got lvl=%0d rdy=%b want 8 0", g2r_level, gpu_ready_out); end
    gpu_data_in = 16'h1409;
    tick();
    tests++; if (g2r_level !== 4'd8) begin
      failed++; $display("FAIL fill_ninth_blocked: got lvl=%0d want 8", g2r_level); end
    router_ready_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      exp = 16'h2000 + 16'(k);
      tests++; if (router_valid_out !== 1'b1 || router_data_out !== exp) begin
        failed++; $display("FAIL drain_order[%0d]: got v=%b d=%h want v=1 d=%h", k, router_valid_out, router_data_out, exp); end
      tick();
      if (k == 1) begin
        tests++; if (g2r_level !== 4'd7) begin
          failed++; $display("FAIL drain_pop_only: got lvl=%0d want 7", g2r_level); end
      end
      if (k == 2) begin
        tests++; if (g2r_level !== 4'd7) begin
          failed++; $display("FAIL push_pop_same_cycle: got lvl=%0d want 7", g2r_level); end
        gpu_valid_in = 1'b0;
      end
    end
    tests++; if (g2r_level !== 4'd0 || router_valid_out !== 1'b0) begin
      failed++; $display("FAIL drain_empty: got lvl=%0d v=%b want 0 0", g2r_level, router_valid_out); end
    router_ready_in = 1'b0;
  endtask

  task automatic test_bad_dest_misroute;
    do_reset();
    router_ready_in = 1'b1;
    gpu_valid_in    = 1'b1;
    gpu_data_in     = 16'h0011;
    tick();
    gpu_data_in     = 16'h8422;
    tick();
    gpu_valid_in    = 1'b0;
    tests++; if (router_valid_out !== 1'b0 || g2r_level !== 4'd0) begin
      failed++; $display("FAIL bad_dest_no_traffic: got v=%b lvl=%0d want 0 0", router_valid_out, g2r_level); end
    tests++; if (bad_dest_cnt !== 8'd2) begin
      failed++; $display("FAIL bad_dest_cnt: got %0d want 2", bad_dest_cnt); end
    router_data_in  = 16'h1C3C;
    router_valid_in = 1'b1;
    tick();
    router_valid_in = 1'b0;
    tests++; if (misroute_cnt !== 8'd1 || r2g_level !== 4'd0 || gpu_valid_out !== 1'b0) begin
      failed++; $display("FAIL misroute: got cnt=%0d lvl=%0d v=%b want 1 0 0", misroute_cnt, r2g_level, gpu_valid_out); end
    router_data_in  = 16'h1955;
    router_valid_in = 1'b1;
    tick();
    router_valid_in = 1'b0;
    tests++; if (gpu_valid_out !== 1'b1 || gpu_data_out !== 16'h0D55 || misroute_cnt !== 8'd1) begin
      failed++; $display("FAIL router_deliver: got v=%b d=%h cnt=%0d want 1 0d55 1", gpu_valid_out, gpu_data_out, misroute_cnt); end
    router_ready_in = 1'b0;
  endtask

  task automatic test_loopback;
    do_reset();
    gpu_data_in  = 16'h0C2A;
    gpu_valid_in = 1'b1;
    tick();
    gpu_valid_in = 1'b0;
    tests++; if (router_valid_out !== 1'b0 || g2r_level !== 4'd1) begin
      failed++; $display("FAIL loop_no_router: got v=%b lvl=%0d want 0 1", router_valid_out, g2r_level); end
    tick();
    tests++; if (gpu_valid_out !== 1'b1 || gpu_data_out !== 16'h0C2A || g2r_level !== 4'd0 || router_valid_out !== 1'b0) begin
      failed++; $display("FAIL loop_deliver: got v=%b d=%h g2r=%0d rv=%b want 1 0c2a 0 0",
                         gpu_valid_out, gpu_data_out, g2r_level, router_valid_out); end
    gpu_ready_in = 1'b1;
    tick();
    gpu_ready_in = 1'b0;
    gpu_valid_in = 1'b1;
    tick();
    gpu_valid_in    = 1'b0;
    router_data_in  = 16'h1955;
    router_valid_in = 1'b1;
    tick();
    router_valid_in = 1'b0;
    tests++; if (r2g_level !== 4'd1 || g2r_level !== 4'd1 || gpu_data_out !== 16'h0D55) begin
      failed++; $display("FAIL loop_router_priority: got r2g=%0d g2r=%0d d=%h want 1 1 0d55", r2g_level, g2r_level, gpu_data_out); end
    tick();
    tests++; if (r2g_level !== 4'd2 || g2r_level !== 4'd0) begin
      failed++; $display("FAIL loop_after_router: got r2g=%0d g2r=%0d want 2 0", r2g_level, g2r_level); end
    gpu_ready_in = 1'b1;
    tests++; if (gpu_data_out !== 16'h0D55) begin
      failed++; $display("FAIL loop_order_first: got %h want 0d55", gpu_data_out); end
    tick();
    tests++; if (gpu_valid_out !== 1'b1 || gpu_data_out !== 16'h0C2A) begin
      failed++; $display("FAIL loop_order_second: got v=%b d=%h want 1 0c2a", gpu_valid_out, gpu_data_out); end
    tick();
    gpu_ready_in = 1'b0;
    tests++; if (gpu_valid_out !== 1'b0 || r2g_level !== 4'd0) begin
      failed++; $display("FAIL loop_drained: got v=%b lvl=%0d want 0 0", gpu_valid_out, r2g_level); end
  endtask

  task automatic test_saturation;
    do_reset();
    gpu_data_in  = 16'h0001;
    gpu_valid_in = 1'b1;
    repeat (254) tick();
    tests++; if (bad_dest_cnt !== 8'd254) begin
      failed++; $display("FAIL sat_before: got %0d want 254", bad_dest_cnt); end
    repeat (6) tick();
    gpu_valid_in = 1'b0;
    tests++; if (bad_dest_cnt !== 8'd255) begin
      failed++; $display("FAIL sat_hold: got %0d want 255", bad_dest_cnt); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    gpu_valid_in    = 1'b1;
    router_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gpu_data_in    = 16'h1400 + 16'(i);
      router_data_in = 16'h1800 + 16'(i);
      tick();
    end
    gpu_data_in    = 16'h0000;
    router_data_in = 16'h1C00;
    tick();
    gpu_valid_in    = 1'b0;
    router_valid_in = 1'b0;
    tests++; if (g2r_level !== 4'd4 || r2g_level !== 4'd4 || bad_dest_cnt !== 8'd1 || misroute_cnt !== 8'd1) begin
      failed++; $display("FAIL mid_prefill: got g2r=%0d r2g=%0d bad=%0d mis=%0d want 4 4 1 1",
                         g2r_level, r2g_level, bad_dest_cnt, misroute_cnt); end
    tests++; if (gpu_data_out !== 16'h0C00) begin
      failed++; $display("FAIL mid_r2g_head: got %h want 0c00", gpu_data_out); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (g2r_level !== 4'd0 || r2g_level !== 4'd0 || gpu_valid_out !== 1'b0 || router_valid_out !== 1'b0) begin
      failed++; $display("FAIL mid_flush: got g2r=%0d r2g=%0d gv=%b rv=%b want 0 0 0 0",
                         g2r_level, r2g_level, gpu_valid_out, router_valid_out); end
    tests++; if (bad_dest_cnt !== 8'd0 || misroute_cnt !== 8'd0 || gpu_ready_out !== 1'b1 || router_ready_out !== 1'b1) begin
      failed++; $display("FAIL mid_counters_readies: got bad=%0d mis=%0d gr=%b rr=%b want 0 0 1 1",
                         bad_dest_cnt, misroute_cnt, gpu_ready_out, router_ready_out); end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_fill_drain();
    test_bad_dest_misroute();
    test_loopback();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
